// File: rtl/rggen_bus_if.sv
// Register bus between an initiator and a slave.
// Master drives the request fields; slave returns ready, status and read data.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     write;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid,
    output address,
    output write,
    output write_data,
    output strobe,
    input  ready,
    input  status,
    input  read_data
  );

  modport slave (
    input  valid,
    input  address,
    input  write,
    input  write_data,
    input  strobe,
    output ready,
    output status,
    output read_data
  );
endinterface

// File: rtl/rggen_bus_initiator.sv
// Single-outstanding command/response bridge onto the register bus.
// Counts slave wait cycles and returns them with the response.
module rggen_bus_initiator #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32,
  parameter int WAIT_WIDTH    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic                     i_cmd_write,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [1:0]               o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic [WAIT_WIDTH-1:0]    o_rsp_wait_cycles,
  rggen_bus_if.master              bus_if
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  localparam logic [WAIT_WIDTH-1:0] WAIT_MAX = '1;

  state_e                   state_q, state_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     bus_valid_q, bus_valid_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic                     write_q, write_d;
  logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
  logic [BUS_WIDTH/8-1:0]   strobe_q, strobe_d;
  logic [1:0]               status_q, status_d;
  logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
  logic [WAIT_WIDTH-1:0]    rsp_wait_q, rsp_wait_d;
  logic [WAIT_WIDTH-1:0]    wait_q, wait_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    bus_valid_d = bus_valid_q;
    rsp_valid_d = rsp_valid_q;
    address_d   = address_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strobe_d    = strobe_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    rsp_wait_d  = rsp_wait_q;
    wait_d      = wait_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (i_cmd_valid) begin
          address_d   = i_cmd_address;
          write_d     = i_cmd_write;
          wdata_d     = i_cmd_write_data;
          strobe_d    = i_cmd_strobe;
          wait_d      = '0;
          cmd_ready_d = 1'b0;
          bus_valid_d = 1'b1;
          state_d     = REQUEST;
        end
      end
      (state_q == REQUEST): begin
        if (bus_if.ready) begin
          status_d    = bus_if.status;
          rdata_d     = write_q ? '0 : bus_if.read_data;
          rsp_wait_d  = wait_q;
          bus_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESPONSE;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + 1'b1;
        end
      end
      (state_q == RESPONSE): begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        cmd_ready_d = 1'b1;
        bus_valid_d = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      bus_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      address_q   <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strobe_q    <= '0;
      status_q    <= '0;
      rdata_q     <= '0;
      rsp_wait_q  <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      bus_valid_q <= bus_valid_d;
      rsp_valid_q <= rsp_valid_d;
      address_q   <= address_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strobe_q    <= strobe_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
      rsp_wait_q  <= rsp_wait_d;
      wait_q      <= wait_d;
    end
  end

  assign o_cmd_ready       = cmd_ready_q;
  assign o_rsp_valid       = rsp_valid_q;
  assign o_rsp_status      = status_q;
  assign o_rsp_read_data   = rdata_q;
  assign o_rsp_wait_cycles = rsp_wait_q;

  assign bus_if.valid      = bus_valid_q;
  assign bus_if.address    = address_q;
  assign bus_if.write      = write_q;
  assign bus_if.write_data = wdata_q;
  assign bus_if.strobe     = strobe_q;

endmodule
